// File: rtl/sigma_delta_multi_counter.sv
// Multi-channel sigma-delta ones counter over programmable sample windows.
// Define SIGMA_DELTA_OVERRUN_COUNT_EN to add the saturating overrun counter.
module sigma_delta_multi_counter #(
  parameter int NUM_CHANNELS = 4,
  parameter int MAX_SAMPLES  = 1000,
  localparam int CW = $clog2(MAX_SAMPLES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       sample_en,
  input  logic [CW-1:0]              window_len,
  input  logic [NUM_CHANNELS-1:0]    pulse,
  input  logic                       out_ready,
  output logic [NUM_CHANNELS*CW-1:0] ones,
  output logic                       out_valid,
  output logic                       overrun,
  output logic                       busy,
  output logic [7:0]                 overrun_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_CHANNELS-1:0][CW-1:0] acc_q, acc_d;
  logic [NUM_CHANNELS-1:0][CW-1:0] ones_q, ones_d;
  logic out_valid_q, out_valid_d;
  logic overrun_q, overrun_d;
  logic len_ok;
  logic xfer;
  logic win_end;

  always_comb begin
    len_ok  = (window_len != '0) &&
              (window_len <= CW'(MAX_SAMPLES));
    xfer    = out_valid_q & out_ready;
    win_end = (state_q == COUNT) & sample_en &
              (cnt_q == len_q - 1'b1);

    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ones_d      = ones_q;
    out_valid_d = out_valid_q & ~xfer;
    overrun_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable && len_ok) begin
          state_d = COUNT;
          len_d   = window_len;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      COUNT: begin
        if (win_end) begin
          for (int i = 0; i < NUM_CHANNELS; i++) begin
            ones_d[i] = acc_q[i] + CW'(pulse[i]);
          end
          out_valid_d = 1'b1;
          // Unconsumed result about to be replaced
          overrun_d   = out_valid_q & ~out_ready;
          acc_d       = '0;
          cnt_d       = '0;
          if (enable && len_ok) begin
            len_d = window_len;
          end else begin
            state_d = IDLE;
          end
        end else if (!enable) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (sample_en) begin
          for (int i = 0; i < NUM_CHANNELS; i++) begin
            acc_d[i] = acc_q[i] + CW'(pulse[i]);
          end
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ones_q      <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ones_q      <= ones_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef SIGMA_DELTA_OVERRUN_COUNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (overrun_d && ovr_cnt_q != 8'hff) begin
      ovr_cnt_d = ovr_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_cnt_q <= '0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign overrun_count = ovr_cnt_q;
`else
  assign overrun_count = '0;
`endif

  assign ones      = ones_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == COUNT);

endmodule

// File: doc/sigma_delta_multi_counter.md
SIGMA_DELTA_MULTI_COUNTER -- requirements
Module: sigma_delta_multi_counter

Interface
REQ-001 Parameter NUM_CHANNELS, default 4: number of independent pulse channels counted in parallel (1..16).
REQ-002 Parameter MAX_SAMPLES, default 1000: largest window length supported; CW = $clog2(MAX_SAMPLES+1).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 enable  input  1  run request; 1 = count windows continuously, 0 = abort and idle.
REQ-006 sample_en  input  1  sample strobe; pulse is sampled only in cycles where sample_en=1.
REQ-007 window_len  input  CW  requested window length in samples, latched at each window start.
REQ-008 pulse  input  NUM_CHANNELS  one sigma-delta bitstream per channel; bit i is channel i.
REQ-009 out_ready  input  1  consumer accepts the current result.
REQ-010 ones  output  NUM_CHANNELS*CW  packed results; channel i is bits [i*CW +: CW].
REQ-011 out_valid  output  1  ones holds an unconsumed result.
REQ-012 overrun  output  1  one-cycle pulse: an unconsumed result was overwritten.
REQ-013 busy  output  1  1 while in COUNT state.
REQ-014 overrun_count  output  8  saturating count of overruns (see Configuration).

Function
REQ-015 The FSM SHALL have two states, IDLE and COUNT; busy = (state == COUNT).
REQ-016 IDLE->COUNT when enable=1 and 1 <= window_len <= MAX_SAMPLES: latch len_q = window_len; clear accumulators and sample counter.
REQ-017 With enable=1 and window_len = 0 or > MAX_SAMPLES, the block SHALL remain in IDLE.
REQ-018 In COUNT, per cycle with sample_en=1: acc[i] += pulse[i] for every channel; sample counter += 1; with sample_en=0, nothing changes.
REQ-019 On the sample where sample counter == len_q-1 (window end), on the next edge: ones <= final acc values including that sample; out_valid <= 1; acc and counter <= 0.
REQ-020 Result latency SHALL be exactly one cycle after the final sampled edge.
REQ-021 At window end with enable=1 and a valid window_len, the block SHALL relatch len_q and start the next window in the following cycle with no dead cycle; with an invalid window_len it SHALL go to IDLE.
REQ-022 At window end with enable=0, the result SHALL still be published and the FSM SHALL go to IDLE.
REQ-023 enable=0 in COUNT before window end SHALL abort: partial counts discarded, no out_valid, IDLE next cycle.
REQ-024 out_valid and ones SHALL remain stable until a transfer (out_valid & out_ready); after the transfer, out_valid <= 0 unless a new result loads in the same edge.
REQ-025 Window end while out_valid=1 and out_ready=0: ones overwritten, out_valid stays 1, overrun = 1 for one cycle.
REQ-026 Window end coinciding with a transfer SHALL load the new result with out_valid=1 and no overrun.
REQ-027 Accumulators SHALL be CW bits wide; an all-ones window of MAX_SAMPLES SHALL yield MAX_SAMPLES without wrap.

Reset
REQ-028 rst=1 SHALL force IDLE, len_q/acc/counter = 0, ones = 0, out_valid = 0, overrun = 0, busy = 0, overrun_count = 0 on the next edge.
REQ-029 rst mid-window or with a pending result SHALL discard all state, with no out_valid after release.
REQ-030 rst SHALL take priority over every other input in the same cycle.

Configuration
REQ-031 Macro SIGMA_DELTA_OVERRUN_COUNT_EN defined: overrun_count increments on each overrun pulse and saturates at 255; it clears only on rst.
REQ-032 Macro not defined: overrun_count SHALL be tied to 0 and no counter register synthesised; all other behaviour is identical.

Verification
REQ-033 NUM_CHANNELS=4, window_len=10, sample_en=1 always, pulse=4'b0101 constant, out_ready=1 -> every 10 cycles ones = {0,10,0,10} (ch3..ch0), out_valid high 1 cycle, no gap between windows.
REQ-034 window_len=8, sample_en every other cycle, ch0 pulse alternating 1/0 per sample -> ones ch0 = 4 after 16 cycles.
REQ-035 out_ready=0 over two consecutive windows of len 5 -> overrun pulses once at the 2nd result; ones = 2nd result; overrun_count = 1 with the macro, 0 without.
REQ-036 enable dropped after 3 of 10 samples -> no out_valid; busy=0 next cycle; re-enable with len 4 -> fresh count from 0.
REQ-037 window_len=0 or MAX_SAMPLES+1 with enable=1 -> stays IDLE; window_len=MAX_SAMPLES with all-ones pulse -> ones = MAX_SAMPLES.
REQ-038 rst asserted mid-window with out_valid=1 -> all outputs 0 next cycle; overrun_count = 0.
